// File: rtl/logic_axi4_stream_packetizer_pkg.sv
// Shared types for the AXI4-Stream packetizer: skid-buffer state encoding
// and a helper for sizing optional payload fields.
package logic_axi4_stream_packetizer_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } skid_state_e;

   function automatic int field_w(input int en, input int w);
      return (en != 0) ? w : 0;
   endfunction

endpackage

// File: rtl/logic_axi4_stream_if.sv
// AXI4-Stream bundle; modport rx is the sink side, tx the source side.
interface logic_axi4_stream_if #(
   parameter int TDATA_BYTES = 1,
   parameter int TDEST_WIDTH = 1,
   parameter int TUSER_WIDTH = 1,
   parameter int TID_WIDTH   = 1
);
   logic                       tvalid;
   logic                       tready;
   logic [8*TDATA_BYTES-1:0]   tdata;
   logic [TDATA_BYTES-1:0]     tstrb;
   logic [TDATA_BYTES-1:0]     tkeep;
   logic                       tlast;
   logic [TDEST_WIDTH-1:0]     tdest;
   logic [TUSER_WIDTH-1:0]     tuser;
   logic [TID_WIDTH-1:0]       tid;

   modport rx (input tvalid, tdata, tstrb, tkeep, tlast, tdest, tuser, tid, output tready);
   modport tx (output tvalid, tdata, tstrb, tkeep, tlast, tdest, tuser, tid, input tready);
endinterface

// File: rtl/logic_axi4_stream_skid.sv
// Two-entry skid buffer with registered ready; head_q always feeds the output
// so a pushed entry is visible the cycle after acceptance.
module logic_axi4_stream_skid
   import logic_axi4_stream_packetizer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             push_valid_i,
   output logic             push_ready_o,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             pop_valid_o,
   input  logic             pop_ready_i
);
   skid_state_e      state_q, state_d;
   logic             ready_q, ready_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] spare_q, spare_d;
   logic             push, pop;

   assign push         = push_valid_i & ready_q;
   assign pop          = pop_valid_o & pop_ready_i;
   assign push_ready_o = ready_q;
   assign pop_valid_o  = (state_q != EMPTY);
   assign pop_data_o   = head_q;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      spare_d = spare_q;
      unique case (state_q)
         EMPTY: begin
            if (push) begin
               head_d  = push_data_i;
               state_d = ONE;
            end
         end
         ONE: begin
            if (push && pop) begin
               head_d = push_data_i;
            end else if (push) begin
               spare_d = push_data_i;
               state_d = FULL;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // ready is low here, so only a pop can occur
            if (pop) begin
               head_d  = spare_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      ready_d = (state_d != FULL);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= EMPTY;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
      end
   end

   always_ff @(posedge clk_i) begin
      head_q  <= head_d;
      spare_q <= spare_d;
   end

endmodule

// File: rtl/logic_axi4_stream_packetizer.sv
// Forwards an AXI4-Stream through a skid buffer, inserting tlast every
// `length` beats (length sampled at each packet's first beat).
module logic_axi4_stream_packetizer
   import logic_axi4_stream_packetizer_pkg::*;
#(
   parameter int TDATA_BYTES  = 1,
   parameter int TDEST_WIDTH  = 1,
   parameter int TUSER_WIDTH  = 1,
   parameter int TID_WIDTH    = 1,
   parameter int USE_TLAST    = 1,
   parameter int USE_TKEEP    = 1,
   parameter int USE_TSTRB    = 1,
   parameter int LENGTH_WIDTH = 16
) (
   input  logic                    aclk,
   input  logic                    areset_n,
   input  logic [LENGTH_WIDTH-1:0] length,
   logic_axi4_stream_if.rx         rx,
   logic_axi4_stream_if.tx         tx
);
   localparam int DATA_W = 8 * TDATA_BYTES;
   localparam int STRB_W = field_w(USE_TSTRB, TDATA_BYTES);
   localparam int KEEP_W = field_w(USE_TKEEP, TDATA_BYTES);
   localparam int O_STRB = DATA_W;
   localparam int O_KEEP = O_STRB + STRB_W;
   localparam int O_LAST = O_KEEP + KEEP_W;
   localparam int O_DEST = O_LAST + 1;
   localparam int O_USER = O_DEST + TDEST_WIDTH;
   localparam int O_ID   = O_USER + TUSER_WIDTH;
   localparam int WIDTH  = O_ID + TID_WIDTH;

   logic [LENGTH_WIDTH-1:0] cnt_q, cnt_d;
   logic [LENGTH_WIDTH-1:0] len_q, len_d;
   logic [LENGTH_WIDTH-1:0] len_eff;
   logic                    accept, first_beat, last_beat;
   wire  [WIDTH-1:0]        push_data;
   wire  [WIDTH-1:0]        pop_data;

   assign accept     = rx.tvalid & rx.tready;
   assign first_beat = (cnt_q == '0);
   // the first beat must see the live length, not the stale latch
   assign len_eff    = first_beat ? length : len_q;
   assign last_beat  = (cnt_q == len_eff - LENGTH_WIDTH'(1)) || ((USE_TLAST != 0) && rx.tlast);

   always_comb begin
      cnt_d = cnt_q;
      len_d = len_q;
      if (accept) begin
         if (first_beat) len_d = length;
         cnt_d = last_beat ? '0 : cnt_q + LENGTH_WIDTH'(1);
      end
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         cnt_q <= '0;
         len_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         len_q <= len_d;
      end
   end

   assign push_data[DATA_W-1:0]                = rx.tdata;
   assign push_data[O_LAST]                    = last_beat;
   assign push_data[O_DEST +: TDEST_WIDTH]     = rx.tdest;
   assign push_data[O_USER +: TUSER_WIDTH]     = rx.tuser;
   assign push_data[O_ID +: TID_WIDTH]         = rx.tid;
   assign tx.tdata                             = pop_data[DATA_W-1:0];
   assign tx.tlast                             = pop_data[O_LAST];
   assign tx.tdest                             = pop_data[O_DEST +: TDEST_WIDTH];
   assign tx.tuser                             = pop_data[O_USER +: TUSER_WIDTH];
   assign tx.tid                               = pop_data[O_ID +: TID_WIDTH];

   generate
      if (USE_TSTRB != 0) begin : g_strb
         assign push_data[O_STRB +: TDATA_BYTES] = rx.tstrb;
         assign tx.tstrb                         = pop_data[O_STRB +: TDATA_BYTES];
      end else begin : g_no_strb
         assign tx.tstrb = '1;
      end
      if (USE_TKEEP != 0) begin : g_keep
         assign push_data[O_KEEP +: TDATA_BYTES] = rx.tkeep;
         assign tx.tkeep                         = pop_data[O_KEEP +: TDATA_BYTES];
      end else begin : g_no_keep
         assign tx.tkeep = '1;
      end
   endgenerate

   logic_axi4_stream_skid #(.WIDTH(WIDTH)) u_skid (
      .clk_i        (aclk),
      .rst_ni       (areset_n),
      .push_data_i  (push_data),
      .push_valid_i (rx.tvalid),
      .push_ready_o (rx.tready),
      .pop_data_o   (pop_data),
      .pop_valid_o  (tx.tvalid),
      .pop_ready_i  (tx.tready)
   );

endmodule

// File: doc/logic_axi4_stream_packetizer.md
LOGIC_AXI4_STREAM_PACKETIZER -- requirements
Module: logic_axi4_stream_packetizer

Interface
REQ-001 SHALL have parameter TDATA_BYTES, default 1: tdata width in bytes.
REQ-002 SHALL have parameter TDEST_WIDTH, default 1: tdest bits.
REQ-003 SHALL have parameter TUSER_WIDTH, default 1: tuser bits.
REQ-004 SHALL have parameter TID_WIDTH, default 1: tid bits.
REQ-005 SHALL have parameter USE_TLAST, default 1: nonzero means rx.tlast terminates packets early; zero means rx.tlast is ignored.
REQ-006 SHALL have parameter USE_TKEEP, default 1: forward tkeep, else drive tx.tkeep all-ones.
REQ-007 SHALL have parameter USE_TSTRB, default 1: forward tstrb, else drive tx.tstrb all-ones.
REQ-008 SHALL have parameter LENGTH_WIDTH, default 16: packet-length counter width.
REQ-009 SHALL have port aclk, input, 1: single clock; all logic on its rising edge.
REQ-010 SHALL have port areset_n, input, 1: reset, asynchronous, active-low.
REQ-011 SHALL have port length, input, LENGTH_WIDTH: beats per packet; 0 means 2^LENGTH_WIDTH beats.
REQ-012 SHALL have port rx, logic_axi4_stream_if rx modport: input stream.
REQ-013 SHALL have port tx, logic_axi4_stream_if tx modport: output stream with generated tlast.

Function
REQ-014 SHALL forward tdata, tkeep, tstrb, tdest, tuser and tid unchanged, beat for beat, with no beat dropped, duplicated or reordered.
REQ-015 SHALL transfer a beat on rx when rx.tvalid and rx.tready are both high, and on tx when tx.tvalid and tx.tready are both high.
REQ-016 SHALL have a latency of exactly 1 cycle: a beat accepted at edge N is presented on tx after edge N.
REQ-017 SHALL buffer through a 2-entry skid buffer with states EMPTY, ONE and FULL.
REQ-018 SHALL drive rx.tready from a register, high in EMPTY and ONE, low in FULL.
REQ-019 SHALL sustain 1 beat/cycle while tx.tready stays high.
REQ-020 SHALL use these skid-buffer transitions:
- EMPTY->ONE on push.
- ONE->FULL on push without pop.
- ONE->EMPTY on pop without push.
- ONE->ONE on push with pop.
- FULL->ONE on pop (no push is possible in FULL).
REQ-021 SHALL hold tx payload and tx.tvalid stable while tx.tvalid=1 and tx.tready=0.
REQ-022 SHALL keep a beat counter that counts accepted rx beats within the current packet, starting at 0.
REQ-023 SHALL sample length into a latch on the first beat of each packet; length changes mid-packet SHALL have no effect until the next packet.
REQ-024 SHALL set tlast on a beat when counter equals latched length minus 1, computed modulo 2^LENGTH_WIDTH so that 0 gives 2^LENGTH_WIDTH.
REQ-025 SHALL, when USE_TLAST is nonzero, also set tlast when rx.tlast=1.
REQ-026 SHALL reset the counter to 0 after every beat carrying tlast; the next beat re-samples length.
REQ-027 SHALL, when length=1, set tlast on every beat.
REQ-028 SHALL compute tlast at rx acceptance and store it alongside the payload in the skid entry.
REQ-029 SHALL NOT wrap the counter across a packet boundary.

Reset
REQ-030 SHALL, while areset_n=0, drive:
- tx.tvalid=0 and rx.tready=0;
- counter=0 and length latch=0;
- skid state EMPTY.
REQ-031 SHALL drive rx.tready=1 on the first edge after areset_n deasserts.
REQ-032 SHALL, on reset assertion mid-packet, discard buffered beats and start a new packet at counter 0 after release.
REQ-033 SHALL apply no reset to datapath payload registers.

Structure
REQ-034 SHALL place the skid state enum (EMPTY, ONE, FULL) in shared package logic_axi4_stream_packetizer_pkg.
REQ-035 SHALL place the 2-entry buffer in sub-module logic_axi4_stream_skid, parameterized by WIDTH and holding packed payload plus tlast.
REQ-036 SHALL pack payload fields in order tdata, tstrb, tkeep, tlast, tdest, tuser, tid, from LSB, omitting disabled fields.

Verification
REQ-037 SHALL cover: length=4, continuous tvalid, tready=1, 12 beats -> tlast on beats 3, 7, 11; 1 beat/cycle; 1-cycle latency.
REQ-038 SHALL cover: length=3, random tready 50% -> payload identical and in order; tx stable while stalled; rx.tready=0 only in FULL.
REQ-039 SHALL cover: USE_TLAST=1, length=8, rx.tlast on beat 2 -> tx.tlast on beat 2; next tlast 8 beats later.
REQ-040 SHALL cover: length changed 4->2 after beat 1 of a packet -> that packet ends at beat 3; the following packet has 2 beats.
REQ-041 SHALL cover: LENGTH_WIDTH=2, length=0 -> tlast every 4 beats; length=1 -> tlast every beat.
REQ-042 SHALL cover: areset_n pulsed low with FULL buffer mid-packet -> tx.tvalid=0 immediately; after release the first beat starts a new count and 4 beats pass before tlast at length=4.
